// File: rtl/cla_pkg.sv
// Shared types and constants for the cla16 issue/collect controller.
package cla_pkg;

    localparam int CLA_W   = 16;
    localparam int CLA_LAT = 2;

    typedef struct packed {
        logic             cout;
        logic [CLA_W-1:0] s;
    } cla_res_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } issue_state_t;

endpackage

// File: rtl/cla_res_fifo.sv
// Synchronous result FIFO for cla_issue_ctrl; registered storage with the head entry exposed directly.
module cla_res_fifo
    import cla_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          i_push,
    input  cla_res_t      i_push_data,
    input  logic          i_pop,
    output logic [CW-1:0] o_count,
    output cla_res_t      o_head
);

    cla_res_t      r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_pop;

    assign w_pop   = i_pop && (r_count != '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rptr];

    // NOTE: sequential state uses <= so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            // NOTE: storage is cleared on reset so the head reads zero until the first result lands.
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wptr] <= i_push_data;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/cla_issue_ctrl.sv
// Issue/collect controller around the 2-stage cla16 adder: credit-gated issue, latency-matched tagging, result FIFO.
// Optional build macro ISSUE_STATS_EN adds stat_issued/stat_stall/stat_bp counters.
module cla_issue_ctrl
    import cla_pkg::*;
#(
    parameter int W     = CLA_W,
    parameter int LAT   = CLA_LAT,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_cin,
    output logic [W-1:0] add_a,
    output logic [W-1:0] add_b,
    output logic         add_cin,
    input  logic [W-1:0] add_s,
    input  logic         add_cout,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_s,
    output logic         out_cout,
    input  logic         drain_req,
    output logic         drain_done
`ifdef ISSUE_STATS_EN
    ,
    output logic [15:0]  stat_issued,
    output logic [15:0]  stat_stall,
    output logic [15:0]  stat_bp
`endif
);

    localparam int SW = $clog2(DEPTH + LAT) + 1;
    localparam int CW = $clog2(DEPTH + 1);

    issue_state_t  r_state;
    issue_state_t  w_next_state;
    logic          r_drain_done;
    logic          w_drain_done;
    logic [LAT-1:0] r_vpipe;
    logic          w_fire;
    logic          w_pop;
    logic [CW-1:0] w_count;
    logic [SW-1:0] w_inflight;
    logic [SW-1:0] w_credit;
    cla_res_t      w_push_data;
    cla_res_t      w_head;

    assign add_a   = in_a;
    assign add_b   = in_b;
    assign add_cin = in_cin;

    // Everything issued but not yet popped holds a FIFO slot, so capture never needs a full check.
    assign w_inflight = SW'($countones(r_vpipe));
    assign w_credit   = SW'(w_count) + w_inflight;
    assign in_ready   = (r_state == RUN) && !drain_req && (w_credit < SW'(DEPTH));
    assign w_fire     = in_valid && in_ready;

    assign out_valid   = (w_count != '0);
    assign w_pop       = out_valid && out_ready;
    assign w_push_data = '{cout: add_cout, s: add_s};
    assign out_s       = w_head.s;
    assign out_cout    = w_head.cout;
    assign drain_done  = r_drain_done;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_vpipe <= '0;
        end else begin
            r_vpipe <= {r_vpipe[LAT-2:0], w_fire};
        end
    end

    cla_res_fifo #(.DEPTH(DEPTH)) u_res_fifo (
        .clk         (clk),
        .rst_b       (rst_b),
        .i_push      (r_vpipe[LAT-1]),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_count     (w_count),
        .o_head      (w_head)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state      <= IDLE;
            r_drain_done <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_drain_done <= w_drain_done;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
        w_next_state = r_state;
        w_drain_done = 1'b0;
        unique case (r_state)
            IDLE:  if (!drain_req) w_next_state = RUN;
            RUN:   if (drain_req)  w_next_state = DRAIN;
            DRAIN: begin
                if ((w_inflight == '0) && (w_count == '0)) begin
                    w_next_state = IDLE;
                    w_drain_done = 1'b1;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

`ifdef ISSUE_STATS_EN
    logic [15:0] r_stat_issued;
    logic [15:0] r_stat_stall;
    logic [15:0] r_stat_bp;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_stat_issued <= '0;
            r_stat_stall  <= '0;
            r_stat_bp     <= '0;
        end else begin
            if (w_fire)                                   r_stat_issued <= r_stat_issued + 1'b1;
            if ((r_state == RUN) && in_valid && !in_ready) r_stat_stall  <= r_stat_stall + 1'b1;
            if (out_valid && !out_ready)                  r_stat_bp     <= r_stat_bp + 1'b1;
        end
    end

    assign stat_issued = r_stat_issued;
    assign stat_stall  = r_stat_stall;
    assign stat_bp     = r_stat_bp;
`endif

endmodule

// File: tb/tb_cla_issue_ctrl.sv
// Randomized self-checking bench for cla_issue_ctrl with a behavioural 2-stage adder and a queue-based reference model.
module tb_cla_issue_ctrl;

    localparam int W       = 16;
    localparam int LAT     = 2;
    localparam int DEPTH   = 4;
    localparam int P_IDLE  = 0;
    localparam int P_RUN   = 1;
    localparam int P_DRAIN = 2;

    logic         clk = 1'b0;
    logic         rst_b;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic [W-1:0] add_a;
    logic [W-1:0] add_b;
    logic         add_cin;
    logic [W-1:0] add_s;
    logic         add_cout;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_s;
    logic         out_cout;
    logic         drain_req;
    logic         drain_done;
`ifdef ISSUE_STATS_EN
    logic [15:0]  stat_issued;
    logic [15:0]  stat_stall;
    logic [15:0]  stat_bp;
`endif

    always #5 clk = ~clk;

    cla_issue_ctrl dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_cin     (in_cin),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_cin    (add_cin),
        .add_s      (add_s),
        .add_cout   (add_cout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_s      (out_s),
        .out_cout   (out_cout),
        .drain_req  (drain_req),
        .drain_done (drain_done)
`ifdef ISSUE_STATS_EN
        ,
        .stat_issued (stat_issued),
        .stat_stall  (stat_stall),
        .stat_bp     (stat_bp)
`endif
    );

    // Behavioural stand-in for cla16: operands sampled at edge k, sum visible after edge k+1.
    logic [W:0] r_add_st1;
    logic [W:0] r_add_st2;
    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_add_st1 <= '0;
            r_add_st2 <= '0;
        end else begin
            r_add_st1 <= {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
            r_add_st2 <= r_add_st1;
        end
    end
    assign add_s    = r_add_st2[W-1:0];
    assign add_cout = r_add_st2[W];

    typedef struct {
        int         ready_at;
        logic [W:0] res;
    } exp_t;

    exp_t        q[$];
    int          cyc;
    int          phase;
    int          n_checks;
    int          n_fail;
    int          n_pops;
    int          n_done_seen;
    logic        e_done;
    logic        last_fire;
    logic        s_in_ready;
    logic [15:0] m_issued;
    logic [15:0] m_stall;
    logic [15:0] m_bp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clear_model();
        q.delete();
        phase    = P_IDLE;
        e_done   = 1'b0;
        m_issued = '0;
        m_stall  = '0;
        m_bp     = '0;
    endtask

    // One clock: compare outputs at the negedge, then advance the model across the posedge.
    task automatic tick();
        logic e_rdy;
        logic e_val;
        logic pop;
        logic rst_seen;
        logic drain_exit;
        int   occ;
        exp_t e;
        @(negedge clk);
        rst_seen = rst_b;
        occ      = q.size();
        e_rdy    = rst_b && (phase == P_RUN) && !drain_req && (occ < DEPTH);
        e_val    = 1'b0;
        if (occ > 0) e_val = (q[0].ready_at <= cyc);
        s_in_ready = in_ready;
        check("in_ready", in_ready, e_rdy);
        check("out_valid", out_valid, e_val);
        if (e_val) check("out_data", {out_cout, out_s}, q[0].res);
        check("drain_done", drain_done, e_done);
`ifdef ISSUE_STATS_EN
        check("stat_issued", stat_issued, m_issued);
        check("stat_stall", stat_stall, m_stall);
        check("stat_bp", stat_bp, m_bp);
`endif
        if (drain_done) n_done_seen++;
        last_fire  = in_valid && e_rdy;
        pop        = e_val && out_ready;
        drain_exit = (phase == P_DRAIN) && (occ == 0);
        @(posedge clk);
        cyc++;
        if (!rst_seen) begin
            clear_model();
        end else begin
            if (last_fire) m_issued = m_issued + 16'd1;
            if ((phase == P_RUN) && in_valid && !e_rdy) m_stall = m_stall + 16'd1;
            if (e_val && !out_ready) m_bp = m_bp + 16'd1;
            if (last_fire) begin
                e.ready_at = cyc + LAT;
                e.res      = {1'b0, in_a} + {1'b0, in_b} + {{W{1'b0}}, in_cin};
                q.push_back(e);
            end
            if (pop) begin
                void'(q.pop_front());
                n_pops++;
            end
            e_done = drain_exit;
            case (phase)
                P_IDLE:  if (!drain_req) phase = P_RUN;
                P_RUN:   if (drain_req) phase = P_DRAIN;
                P_DRAIN: if (drain_exit) phase = P_IDLE;
                default: phase = P_IDLE;
            endcase
        end
        #1;
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = c;
        for (int t = 0; t < 64; t++) begin
            tick();
            if (last_fire) break;
        end
        check("issue_fire", s_in_ready, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic flush();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 64; t++) begin
            tick();
            if (q.size() == 0) break;
        end
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int fires;
        int pops0;
        int done0;
        n_checks    = 0;
        n_fail      = 0;
        n_pops      = 0;
        n_done_seen = 0;
        cyc         = 0;
        clear_model();
        rst_b     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b0;
        drain_req = 1'b0;
        #1;

        // Reset state
        for (int i = 0; i < 3; i++) tick();
        check("rst_out_data", {out_cout, out_s}, 17'h0);
        rst_b = 1'b1;

        // Single op: 0x0000 + 0xFFFF + 1 -> {1, 0x0000} two edges later
        issue(16'h0000, 16'hFFFF, 1'b1);
        tick();
        tick();
        check("single_valid", out_valid, 1'b1);
        check("single_data", {out_cout, out_s}, 17'h1_0000);
        flush();

        // Streaming at one per cycle
        pops0     = n_pops;
        in_valid  = 1'b1;
        in_b      = 16'hFFFF;
        in_cin    = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            in_a = W'(i);
            tick();
            check("stream_ready", s_in_ready, 1'b1);
        end
        flush();
        check("stream_pops", n_pops - pops0, 1024);

        // Backpressure: credits stop issue after DEPTH fires
        fires     = 0;
        pops0     = n_pops;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_a   = W'($urandom);
            in_b   = W'($urandom);
            in_cin = 1'($urandom);
            tick();
            if (s_in_ready) fires++;
        end
        check("bp_fires", fires, DEPTH);
        flush();
        check("bp_pops", n_pops - pops0, DEPTH);

        // Push/pop collisions with a half-rate consumer
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_a      = W'($urandom);
            in_b      = W'($urandom);
            in_cin    = 1'($urandom);
            out_ready = 1'(i % 2);
            tick();
        end
        flush();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom);
            in_a      = W'($urandom);
            in_b      = W'($urandom);
            in_cin    = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        flush();

        // Drain with a stalled consumer, then release it
        out_ready = 1'b0;
        issue(16'h1234, 16'h1111, 1'b0);
        issue(16'hFFFF, 16'h0001, 1'b0);
        issue(16'h8000, 16'h8000, 1'b1);
        done0     = n_done_seen;
        drain_req = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("drain_wait", n_done_seen - done0, 0);
        out_ready = 1'b1;
        for (int t = 0; t < 32; t++) begin
            tick();
            if (n_done_seen != done0) break;
        end
        for (int i = 0; i < 4; i++) tick();
        check("drain_pulses", n_done_seen - done0, 1);
        drain_req = 1'b0;
        in_valid  = 1'b0;
        tick();
        tick();
        check("drain_rerun", s_in_ready, 1'b1);

        // Reset with two ops in the pipe and two in the FIFO
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_a = W'($urandom);
            in_b = W'($urandom);
            tick();
        end
        #2;
        rst_b = 1'b0;
        #1;
        check("rst_async_valid", out_valid, 1'b0);
        check("rst_async_ready", in_ready, 1'b0);
        clear_model();
        in_valid = 1'b0;
        tick();
        tick();
        rst_b     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();

        // Alive after reset
        issue(16'h00FF, 16'h0F0F, 1'b1);
        flush();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
